sd_sector_buffer: RTL and testbench
===================================

Name: sd_sector_buffer

Overview:
Sector-level bridge between the CPU bus and sd_controller; sits directly upstream of the SD controller.
- Holds one 512-byte sector in a dual-port buffer.
- Converts a single CPU command (read or write sector N) into the controller's rd/wr, byte_available and ready_for_next_byte handshakes.
- Reports busy, done and timeout status to the CPU.

Parameters:
- SECTOR_BYTES, 512, bytes per transfer; fixed by SD sectoring.
- TIMEOUT_CYCLES, 16777216, clk cycles allowed from issue to completion before error is flagged.

Ports:
- clk  in  1  system clock, 25 MHz (same clock as sd_controller).
- reset  in  1  synchronous, active-high reset.
- cpu_addr  in  9  buffer byte index for CPU access.
- cpu_wdata  in  8  CPU write data.
- cpu_we  in  1  CPU buffer write strobe.
- cpu_rdata  out  8  buffer byte at cpu_addr; 1-cycle latency.
- cmd_read  in  1  pulse: load sector into buffer.
- cmd_write  in  1  pulse: write buffer to sector.
- sector  in  23  sector number, sampled on the accepted command.
- busy  out  1  transfer in progress.
- done  out  1  one-cycle pulse on successful completion.
- error  out  1  sticky timeout flag; cleared by next accepted command.
- sd_address  out  32  {sector, 9'b0} to the controller.
- sd_rd  out  1  controller read-enable.
- sd_wr  out  1  controller write-enable.
- sd_dout  in  8  controller read data.
- sd_byte_available  in  1  one-cycle pulse: sd_dout valid.
- sd_din  out  8  controller write data.
- sd_ready_for_next_byte  in  1  controller byte-request level.
- sd_ready  in  1  controller idle.

Behaviour:
- Reset values: busy=0, done=0, error=0, sd_rd=0, sd_wr=0, sd_address=0, sd_din=8'hFF, cpu_rdata=0. Byte index=0, FSM=IDLE. Buffer contents are not cleared.
- FSM states: IDLE, WAIT_READY, ISSUE, XFER, FINISH.
- IDLE:
  - cmd_read or cmd_write latches sector into sd_address, latches direction, clears index/timeout/error, sets busy, and goes to WAIT_READY.
  - If both are high in the same cycle, read wins.
  - Commands arriving while busy are ignored, with no queueing.
- WAIT_READY: stay until sd_ready=1, then go to ISSUE.
- ISSUE:
  - Hold sd_rd (read) or sd_wr (write) high until sd_ready=0, then drop it and go to XFER.
  - Never assert sd_rd and sd_wr together.
- XFER, read:
  - Each cycle with sd_byte_available=1 and index<512: buffer[index]<=sd_dout, index++.
  - Pulses after index reaches 512 are ignored.
- XFER, write:
  - sd_din is registered from buffer[index] every cycle.
  - index advances on each falling edge of sd_ready_for_next_byte, except the first.
  - The controller raises sd_ready_for_next_byte once during its command phase; that first fall is discarded.
  - index saturates at 512.
- XFER exit: sd_ready returns to 1 with index==512 -> FINISH.
- FINISH: done=1 for one cycle, busy=0, then IDLE.
- Short transfer: sd_ready returns with index<512. This is treated as a timeout-class failure: error=1, no done pulse, go to IDLE.
- Timeout: a 24-bit counter runs from WAIT_READY through XFER. On reaching TIMEOUT_CYCLES-1: error=1, busy=0, sd_rd=sd_wr=0, go to IDLE. The controller is not aborted; the CPU must reset the system.
- CPU port:
  - Reads are always allowed; during a read transfer they may return partially updated data.
  - cpu_we is ignored while busy=1, so a write transfer sends a stable image.
  - When not busy, a CPU write takes effect at the clock edge. A same-address read in the next cycle returns the new value.
- Reset mid-transfer: immediately IDLE with all outputs at reset values. Buffer contents are undefined.
- Edge detection of sd_ready_for_next_byte uses a 1-cycle delayed copy, reset to 0.

Decomposition:
- Shared package sd_pkg holds:
  - state encodings (SB_IDLE..SB_FINISH)
  - SECTOR_BYTES
  - the sector-to-address shift constant (9)
- Natural sub-module: sector_ram, 512x8 true dual-port, synchronous read.
  - Port A: CPU.
  - Port B: SD side, with write from sd_dout and read to sd_din.
- Bench model sd_controller_bfm mimics the controller's handshakes: ready drop, a command-phase request pulse, 512 byte pulses spaced 16 clk apart, and a trailing CRC pulse.

Test Plan:
- Reset, then CPU writes 0x00..0xFF, 0x00..0xFF to addresses 0..511, then reads back -> cpu_rdata matches each byte one cycle after its address.
- cmd_read, sector=5, BFM supplies byte i = i^8'hA5 -> sd_address=32'h00000A00, sd_rd held until sd_ready=0, done pulse once, buffer[i]==i^8'hA5, 513th (CRC) pulse ignored.
- cmd_write, sector=1, buffer preloaded with i[7:0] -> sd_wr asserted, BFM captures 512 bytes 0x00..0xFF twice in order (command-phase pulse not counted), done=1.
- cmd_read and cmd_write in the same cycle -> only sd_rd asserted; a cmd_write while busy is ignored, with sd_address unchanged.
- BFM never returns sd_ready, with TIMEOUT_CYCLES=1000 -> error=1 at cycle 1000, busy=0, no done; next cmd_read clears error.
- reset asserted midway through a read -> next cycle busy=0, sd_rd=0, done=0, FSM IDLE; a fresh cmd_read then completes normally.

Source files
------------

// File: rtl/sd_pkg.sv
// Shared constants, state encodings and helpers for the SD sector buffer.
package sd_pkg;

    localparam int SECTOR_BYTES = 512;
    localparam int SECTOR_SHIFT = 9;

    localparam logic [2:0] SB_IDLE       = 3'd0;
    localparam logic [2:0] SB_WAIT_READY = 3'd1;
    localparam logic [2:0] SB_ISSUE      = 3'd2;
    localparam logic [2:0] SB_XFER       = 3'd3;
    localparam logic [2:0] SB_FINISH     = 3'd4;

    typedef enum logic {
        DIR_READ  = 1'b0,
        DIR_WRITE = 1'b1
    } sb_dir_e;

    function automatic logic [31:0] sector_to_addr(input logic [22:0] sector);
        return {sector, {SECTOR_SHIFT{1'b0}}};
    endfunction

endpackage

// File: rtl/sector_ram.sv
// 512x8 true dual-port sector RAM with synchronous reads.
// Port A serves the CPU; port B serves the SD controller side.
module sector_ram
    import sd_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [8:0] a_addr,
    input  logic       a_we,
    input  logic [7:0] a_wdata,
    output logic [7:0] a_rdata,
    input  logic [8:0] b_addr,
    input  logic       b_we,
    input  logic [7:0] b_wdata,
    output logic [7:0] b_rdata
);

    logic [7:0] mem [SECTOR_BYTES];
    logic [7:0] a_rdata_q, a_rdata_d;
    logic [7:0] b_rdata_q, b_rdata_d;

    always_comb begin
        a_rdata_d = mem[a_addr];
        b_rdata_d = mem[b_addr];
    end

    // Both ports share one process; the owning FSM never lets them write together.
    always_ff @(posedge clk) begin
        if (a_we) begin
            mem[a_addr] <= a_wdata;
        end
        if (b_we) begin
            mem[b_addr] <= b_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            a_rdata_q <= 8'h00;
        end else begin
            a_rdata_q <= a_rdata_d;
        end
        b_rdata_q <= b_rdata_d;
    end

    assign a_rdata = a_rdata_q;
    assign b_rdata = b_rdata_q;

endmodule

// File: rtl/sd_sector_buffer.sv
// Sector buffer turning one CPU read/write-sector command into sd_controller
// handshakes; reports busy, a done pulse and a sticky timeout error.
module sd_sector_buffer
    import sd_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16777216
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [8:0]  cpu_addr,
    input  logic [7:0]  cpu_wdata,
    input  logic        cpu_we,
    output logic [7:0]  cpu_rdata,
    input  logic        cmd_read,
    input  logic        cmd_write,
    input  logic [22:0] sector,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [31:0] sd_address,
    output logic        sd_rd,
    output logic        sd_wr,
    input  logic [7:0]  sd_dout,
    input  logic        sd_byte_available,
    output logic [7:0]  sd_din,
    input  logic        sd_ready_for_next_byte,
    input  logic        sd_ready
);

    // state         | meaning
    // SB_IDLE       | waiting for cmd_read / cmd_write
    // SB_WAIT_READY | command latched, waiting for controller idle
    // SB_ISSUE      | sd_rd/sd_wr held until the controller drops sd_ready
    // SB_XFER       | moving bytes until the controller raises sd_ready again
    // SB_FINISH     | one-cycle done pulse

    localparam logic [23:0] TMR_LOAD = 24'(TIMEOUT_CYCLES - 1);
    localparam logic [9:0]  IDX_END  = 10'(SECTOR_BYTES);

    logic [2:0]  state_q, state_d;
    sb_dir_e     dir_q, dir_d;
    logic [9:0]  idx_q, idx_d;
    logic [23:0] tmr_q, tmr_d;
    logic        first_fall_q, first_fall_d;
    logic        rfnb_q, rfnb_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        error_q, error_d;
    logic        sd_rd_q, sd_rd_d;
    logic        sd_wr_q, sd_wr_d;
    logic [31:0] sd_address_q, sd_address_d;
    logic [7:0]  sd_din_q, sd_din_d;

    logic        active;
    logic        rfnb_fall;
    logic        ram_a_we;
    logic        ram_b_we;
    logic [7:0]  ram_b_rdata;

    sector_ram u_sector_ram (
        .clk     (clk),
        .reset   (reset),
        .a_addr  (cpu_addr),
        .a_we    (ram_a_we),
        .a_wdata (cpu_wdata),
        .a_rdata (cpu_rdata),
        .b_addr  (idx_q[8:0]),
        .b_we    (ram_b_we),
        .b_wdata (sd_dout),
        .b_rdata (ram_b_rdata)
    );

    // CPU writes are locked out during a transfer so a write sends a stable image.
    assign ram_a_we = cpu_we && !busy_q;

    always_comb begin
        state_d      = state_q;
        dir_d        = dir_q;
        idx_d        = idx_q;
        tmr_d        = tmr_q;
        first_fall_d = first_fall_q;
        rfnb_d       = sd_ready_for_next_byte;
        busy_d       = busy_q;
        done_d       = 1'b0;
        error_d      = error_q;
        sd_rd_d      = sd_rd_q;
        sd_wr_d      = sd_wr_q;
        sd_address_d = sd_address_q;
        ram_b_we     = 1'b0;

        active    = (state_q == SB_WAIT_READY) || (state_q == SB_ISSUE) ||
                    (state_q == SB_XFER);
        rfnb_fall = rfnb_q && !sd_ready_for_next_byte;

        // The controller requests once during its command phase; that fall carries no byte.
        if ((state_q == SB_ISSUE || state_q == SB_XFER) && dir_q == DIR_WRITE && rfnb_fall) begin
            if (first_fall_q) begin
                first_fall_d = 1'b0;
            end else if (idx_q < IDX_END) begin
                idx_d = idx_q + 10'd1;
            end
        end

        case (state_q)
            SB_IDLE: begin
                if (cmd_read || cmd_write) begin
                    sd_address_d = sector_to_addr(sector);
                    dir_d        = cmd_read ? DIR_READ : DIR_WRITE;
                    idx_d        = 10'd0;
                    tmr_d        = TMR_LOAD;
                    first_fall_d = 1'b1;
                    error_d      = 1'b0;
                    busy_d       = 1'b1;
                    state_d      = SB_WAIT_READY;
                end
            end
            SB_WAIT_READY: begin
                if (sd_ready) begin
                    sd_rd_d = (dir_q == DIR_READ);
                    sd_wr_d = (dir_q == DIR_WRITE);
                    state_d = SB_ISSUE;
                end
            end
            SB_ISSUE: begin
                if (!sd_ready) begin
                    sd_rd_d = 1'b0;
                    sd_wr_d = 1'b0;
                    state_d = SB_XFER;
                end
            end
            SB_XFER: begin
                if (dir_q == DIR_READ && sd_byte_available && idx_q < IDX_END) begin
                    ram_b_we = 1'b1;
                    idx_d    = idx_q + 10'd1;
                end
                if (sd_ready) begin
                    busy_d = 1'b0;
                    if (idx_q == IDX_END) begin
                        done_d  = 1'b1;
                        state_d = SB_FINISH;
                    end else begin
                        error_d = 1'b1;
                        state_d = SB_IDLE;
                    end
                end
            end
            SB_FINISH: begin
                state_d = SB_IDLE;
            end
            default: begin
                state_d = SB_IDLE;
            end
        endcase

        // Timeout abandons the transfer locally; the controller itself is left as is.
        if (active) begin
            if (tmr_q == 24'd0) begin
                state_d  = SB_IDLE;
                error_d  = 1'b1;
                busy_d   = 1'b0;
                done_d   = 1'b0;
                sd_rd_d  = 1'b0;
                sd_wr_d  = 1'b0;
                ram_b_we = 1'b0;
            end else begin
                tmr_d = tmr_q - 24'd1;
            end
        end

        sd_din_d = (active && dir_q == DIR_WRITE) ? ram_b_rdata : 8'hFF;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= SB_IDLE;
            dir_q        <= DIR_READ;
            idx_q        <= 10'd0;
            tmr_q        <= 24'd0;
            first_fall_q <= 1'b0;
            rfnb_q       <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
            sd_rd_q      <= 1'b0;
            sd_wr_q      <= 1'b0;
            sd_address_q <= 32'd0;
            sd_din_q     <= 8'hFF;
        end else begin
            state_q      <= state_d;
            dir_q        <= dir_d;
            idx_q        <= idx_d;
            tmr_q        <= tmr_d;
            first_fall_q <= first_fall_d;
            rfnb_q       <= rfnb_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            error_q      <= error_d;
            sd_rd_q      <= sd_rd_d;
            sd_wr_q      <= sd_wr_d;
            sd_address_q <= sd_address_d;
            sd_din_q     <= sd_din_d;
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign error      = error_q;
    assign sd_rd      = sd_rd_q;
    assign sd_wr      = sd_wr_q;
    assign sd_address = sd_address_q;
    assign sd_din     = sd_din_q;

endmodule

// File: tb/tb_sd_sector_buffer.sv
// Self-checking bench for sd_sector_buffer: randomized CPU traffic and sector
// transfers against an array model, with a controller BFM and a timeout instance.
module tb_sd_sector_buffer;

    logic clk = 1'b0;
    always #20 clk = ~clk;

    logic        reset;
    logic [8:0]  cpu_addr;
    logic [7:0]  cpu_wdata;
    logic        cpu_we;
    logic [7:0]  cpu_rdata;
    logic        cmd_read, cmd_write;
    logic [22:0] sector;
    logic        busy, done, error;
    logic [31:0] sd_address;
    logic        sd_rd, sd_wr;
    logic [7:0]  sd_dout;
    logic        sd_byte_available;
    logic [7:0]  sd_din;
    logic        sd_rfnb;
    logic        sd_ready;

    // second instance with a short timeout and a controller that never comes back
    logic [8:0]  t_cpu_addr  = 9'd0;
    logic [7:0]  t_cpu_wdata = 8'd0;
    logic        t_cpu_we    = 1'b0;
    logic [7:0]  t_cpu_rdata;
    logic        t_cmd_read  = 1'b0;
    logic        t_cmd_write = 1'b0;
    logic [22:0] t_sector    = 23'd3;
    logic        t_busy, t_done, t_error;
    logic [31:0] t_sd_address;
    logic        t_sd_rd, t_sd_wr;
    logic [7:0]  t_sd_din;
    logic        t_sd_ready  = 1'b1;

    sd_sector_buffer dut (
        .clk(clk), .reset(reset),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_we(cpu_we), .cpu_rdata(cpu_rdata),
        .cmd_read(cmd_read), .cmd_write(cmd_write), .sector(sector),
        .busy(busy), .done(done), .error(error),
        .sd_address(sd_address), .sd_rd(sd_rd), .sd_wr(sd_wr),
        .sd_dout(sd_dout), .sd_byte_available(sd_byte_available), .sd_din(sd_din),
        .sd_ready_for_next_byte(sd_rfnb), .sd_ready(sd_ready)
    );

    sd_sector_buffer #(.TIMEOUT_CYCLES(1000)) dut_to (
        .clk(clk), .reset(reset),
        .cpu_addr(t_cpu_addr), .cpu_wdata(t_cpu_wdata), .cpu_we(t_cpu_we), .cpu_rdata(t_cpu_rdata),
        .cmd_read(t_cmd_read), .cmd_write(t_cmd_write), .sector(t_sector),
        .busy(t_busy), .done(t_done), .error(t_error),
        .sd_address(t_sd_address), .sd_rd(t_sd_rd), .sd_wr(t_sd_wr),
        .sd_dout(8'h00), .sd_byte_available(1'b0), .sd_din(t_sd_din),
        .sd_ready_for_next_byte(1'b0), .sd_ready(t_sd_ready)
    );

    always @(negedge clk) begin
        if (t_sd_rd || t_sd_wr) t_sd_ready = 1'b0;
    end

    int n_cmp = 0;
    int n_bad = 0;
    int done_cnt = 0, wr_cyc = 0, t_done_cnt = 0;

    always @(negedge clk) begin
        if (done) done_cnt++;
        if (sd_wr) wr_cyc++;
        if (t_done) t_done_cnt++;
    end

    logic [7:0] model   [512];
    bit         known   [512];
    logic [7:0] rd_data [512];
    logic [7:0] cap [$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cpu_write(input int a, input logic [7:0] d);
        @(negedge clk);
        cpu_addr  = 9'(a);
        cpu_wdata = d;
        cpu_we    = 1'b1;
        @(negedge clk);
        cpu_we    = 1'b0;
        model[a]  = d;
        known[a]  = 1'b1;
    endtask

    task automatic cpu_read_chk(input int a, input string tag);
        @(negedge clk);
        cpu_addr = 9'(a);
        @(posedge clk);
        #1;
        if (known[a]) chk(tag, cpu_rdata, model[a]);
    endtask

    task automatic readback_all(input string tag);
        for (int i = 0; i < 512; i++) cpu_read_chk(i, tag);
    endtask

    task automatic issue_cmd(input bit r, input bit w, input logic [22:0] sec);
        @(negedge clk);
        cmd_read  = r;
        cmd_write = w;
        sector    = sec;
        @(negedge clk);
        cmd_read  = 1'b0;
        cmd_write = 1'b0;
    endtask

    // Controller BFM: ready drop, command-phase request (writes), byte pulses 16 clk apart, CRC pulse.
    task automatic bfm_serve(input bit rd_dir, input int nbytes, input bit crc, input bit ret_ready,
                             input logic [31:0] exp_addr, input string tag);
        bit seen;
        seen = 1'b0;
        for (int w = 0; w < 64; w++) begin
            @(negedge clk);
            if (rd_dir ? sd_rd : sd_wr) begin
                seen = 1'b1;
                break;
            end
        end
        chk({tag, " strobe"}, seen, 1'b1);
        if (!seen) return;
        chk({tag, " addr"}, sd_address, exp_addr);
        @(negedge clk);
        chk({tag, " strobe held"}, rd_dir ? sd_rd : sd_wr, 1'b1);
        sd_ready = 1'b0;
        @(negedge clk);
        chk({tag, " strobe release"}, rd_dir ? sd_rd : sd_wr, 1'b0);
        if (!rd_dir) begin
            repeat (3) @(negedge clk);
            sd_rfnb = 1'b1;
            repeat (3) @(negedge clk);
            sd_rfnb = 1'b0;
        end
        for (int k = 0; k < nbytes + (crc ? 1 : 0); k++) begin
            repeat (12) @(negedge clk);
            if (rd_dir) begin
                sd_dout = (k < nbytes) ? rd_data[k] : 8'h3C;
                sd_byte_available = 1'b1;
                @(negedge clk);
                sd_byte_available = 1'b0;
                repeat (3) @(negedge clk);
            end else begin
                sd_rfnb = 1'b1;
                repeat (3) @(negedge clk);
                if (k < nbytes) cap.push_back(sd_din);
                @(negedge clk);
                sd_rfnb = 1'b0;
            end
        end
        repeat (6) @(negedge clk);
        if (ret_ready) sd_ready = 1'b1;
    endtask

    task automatic wait_done(input string tag);
        bit seen;
        seen = 1'b0;
        for (int w = 0; w < 200; w++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        chk(tag, seen, 1'b1);
    endtask

    task automatic run_read(input logic [22:0] sec, input string tag);
        int d0;
        d0 = done_cnt;
        issue_cmd(1'b1, 1'b0, sec);
        chk({tag, " busy"}, busy, 1'b1);
        chk({tag, " err clr"}, error, 1'b0);
        bfm_serve(1'b1, 512, 1'b1, 1'b1, {sec, 9'd0}, tag);
        wait_done({tag, " done"});
        repeat (4) @(negedge clk);
        chk({tag, " done count"}, done_cnt - d0, 1);
        chk({tag, " idle"}, busy, 1'b0);
        for (int i = 0; i < 512; i++) begin
            model[i] = rd_data[i];
            known[i] = 1'b1;
        end
        readback_all({tag, " buf"});
    endtask

    task automatic check_write(input logic [22:0] sec, input string tag);
        int d0;
        d0 = done_cnt;
        cap.delete();
        issue_cmd(1'b0, 1'b1, sec);
        fork
            bfm_serve(1'b0, 512, 1'b1, 1'b1, {sec, 9'd0}, tag);
            begin
                repeat (300) @(negedge clk);
                cpu_addr  = 9'd511;
                cpu_wdata = ~model[511];
                cpu_we    = 1'b1;
                @(negedge clk);
                cpu_we    = 1'b0;
            end
        join
        wait_done({tag, " done"});
        repeat (4) @(negedge clk);
        chk({tag, " done count"}, done_cnt - d0, 1);
        chk({tag, " bytes"}, cap.size(), 512);
        for (int i = 0; i < 512 && i < cap.size(); i++) chk({tag, " byte"}, cap[i], model[i]);
        cpu_read_chk(511, {tag, " locked cpu_we"});
    endtask

    initial begin
        #(40 * 100000);
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [22:0] sec;
        int d0, w0;
        reset = 1'b1;
        cpu_addr = 9'd0; cpu_wdata = 8'd0; cpu_we = 1'b0;
        cmd_read = 1'b0; cmd_write = 1'b0; sector = 23'd0;
        sd_dout = 8'd0; sd_byte_available = 1'b0; sd_rfnb = 1'b0; sd_ready = 1'b1;
        for (int i = 0; i < 512; i++) known[i] = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst busy", busy, 1'b0);
        chk("rst done", done, 1'b0);
        chk("rst error", error, 1'b0);
        chk("rst sd_rd", sd_rd, 1'b0);
        chk("rst sd_wr", sd_wr, 1'b0);
        chk("rst sd_address", sd_address, 32'd0);
        chk("rst sd_din", sd_din, 8'hFF);
        chk("rst cpu_rdata", cpu_rdata, 8'h00);
        chk("rst t_busy", t_busy, 1'b0);
        reset = 1'b0;

        for (int i = 0; i < 512; i++) cpu_write(i, 8'(i));
        readback_all("cpu fill");
        for (int n = 0; n < 64; n++) begin
            int a;
            a = int'($urandom_range(0, 511));
            cpu_write(a, 8'($urandom));
            cpu_read_chk(a, "cpu rand");
        end

        for (int i = 0; i < 512; i++) rd_data[i] = 8'(i) ^ 8'hA5;
        run_read(23'd5, "rd5");

        for (int i = 0; i < 512; i++) cpu_write(i, 8'(i));
        check_write(23'd1, "wr1");

        for (int i = 0; i < 512; i++) cpu_write(i, 8'($urandom));
        check_write(23'($urandom), "wr rand");

        for (int i = 0; i < 512; i++) rd_data[i] = 8'($urandom);
        sec = 23'($urandom);
        d0 = done_cnt;
        w0 = wr_cyc;
        issue_cmd(1'b1, 1'b1, sec);
        fork
            bfm_serve(1'b1, 512, 1'b1, 1'b1, {sec, 9'd0}, "both");
            begin
                repeat (400) @(negedge clk);
                sector    = sec ^ 23'h155;
                cmd_write = 1'b1;
                @(negedge clk);
                cmd_write = 1'b0;
                @(negedge clk);
                chk("busy cmd addr", sd_address, {sec, 9'd0});
            end
        join
        wait_done("both done");
        repeat (4) @(negedge clk);
        chk("both done count", done_cnt - d0, 1);
        chk("both no sd_wr", wr_cyc - w0, 0);
        for (int i = 0; i < 512; i++) model[i] = rd_data[i];
        readback_all("both buf");

        for (int i = 0; i < 512; i++) rd_data[i] = 8'($urandom);
        sec = 23'($urandom);
        d0 = done_cnt;
        issue_cmd(1'b1, 1'b0, sec);
        bfm_serve(1'b1, 100, 1'b0, 1'b1, {sec, 9'd0}, "short");
        repeat (3) @(negedge clk);
        chk("short error", error, 1'b1);
        chk("short busy", busy, 1'b0);
        chk("short no done", done_cnt - d0, 0);
        for (int i = 0; i < 100; i++) model[i] = rd_data[i];
        cpu_read_chk(99, "short buf");

        sec = 23'($urandom);
        issue_cmd(1'b1, 1'b0, sec);
        chk("mid err clr", error, 1'b0);
        bfm_serve(1'b1, 256, 1'b0, 1'b0, {sec, 9'd0}, "mid");
        reset = 1'b1;
        @(negedge clk);
        chk("mid rst busy", busy, 1'b0);
        chk("mid rst sd_rd", sd_rd, 1'b0);
        chk("mid rst done", done, 1'b0);
        chk("mid rst addr", sd_address, 32'd0);
        chk("mid rst sd_din", sd_din, 8'hFF);
        reset = 1'b0;
        sd_ready = 1'b1;
        for (int i = 0; i < 512; i++) known[i] = 1'b0;
        for (int i = 0; i < 512; i++) rd_data[i] = 8'($urandom);
        run_read(23'($urandom), "fresh");

        @(negedge clk);
        t_cmd_read = 1'b1;
        @(posedge clk);
        #1;
        t_cmd_read = 1'b0;
        chk("to accept busy", t_busy, 1'b1);
        repeat (999) @(posedge clk);
        #1;
        chk("to 999 error", t_error, 1'b0);
        chk("to 999 busy", t_busy, 1'b1);
        @(posedge clk);
        #1;
        chk("to 1000 error", t_error, 1'b1);
        chk("to 1000 busy", t_busy, 1'b0);
        chk("to 1000 sd_rd", t_sd_rd, 1'b0);
        chk("to no done", t_done_cnt, 0);
        @(negedge clk);
        t_cmd_read = 1'b1;
        @(posedge clk);
        #1;
        t_cmd_read = 1'b0;
        chk("to err cleared", t_error, 1'b0);
        chk("to rebusy", t_busy, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
